// File: rtl/sblock_pkg.sv
// rtl/sblock_pkg.sv - shared constants and types for the s_block switch block
package sblock_pkg;
   localparam int TRACKS = 3;
   localparam int SEL_W  = 3;
   localparam int CFG_W  = 18;

   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [TRACKS-1:0] track_t;
   typedef logic [CFG_W-1:0]  cfg_t;

   localparam sel_t SEL_ZERO  = 3'd0;
   localparam sel_t SEL_LEFT0 = 3'd1;
   localparam sel_t SEL_UP0   = 3'd4;
   localparam sel_t SEL_ONE   = 3'd7;

   localparam int H_BASE = 9;
   localparam int V_BASE = 0;
endpackage

// File: rtl/sblock_mux8.sv
// rtl/sblock_mux8.sv - 8:1 track selector (constants 0/1, three left, three up)
module sblock_mux8
   import sblock_pkg::*;
(
   input  logic [SEL_W-1:0]  sel,
   input  logic [TRACKS-1:0] left,
   input  logic [TRACKS-1:0] up,
   output logic              y
);

   always_comb begin
      y = 1'b0;
      unique case (sel)
         SEL_ZERO:           y = 1'b0;
         SEL_LEFT0:          y = left[0];
         SEL_LEFT0 + 3'd1:   y = left[1];
         SEL_LEFT0 + 3'd2:   y = left[2];
         SEL_UP0:            y = up[0];
         SEL_UP0 + 3'd1:     y = up[1];
         SEL_UP0 + 3'd2:     y = up[2];
         SEL_ONE:            y = 1'b1;
         default:            y = 1'b0;
      endcase
   end

endmodule

// File: rtl/s_block.sv
// rtl/s_block.sv - configurable switch block: cfg register plus six track muxes
module s_block
   import sblock_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en,
   input  logic [CFG_W-1:0]  bits,
   input  logic [TRACKS-1:0] left_i,
   input  logic [TRACKS-1:0] up_i,
   output logic [TRACKS-1:0] right_o,
   output logic [TRACKS-1:0] down_o
);

   cfg_t cfg;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         cfg <= '0;
      else if (wr_en)
         cfg <= bits;
   end

   // Routing stays combinational so data crosses the block with no latency.
   for (genvar k = 0; k < TRACKS; k++) begin : g_track
      sblock_mux8 u_h (
         .sel  (cfg[H_BASE + SEL_W*k +: SEL_W]),
         .left (left_i),
         .up   (up_i),
         .y    (right_o[k])
      );
      sblock_mux8 u_v (
         .sel  (cfg[V_BASE + SEL_W*k +: SEL_W]),
         .left (left_i),
         .up   (up_i),
         .y    (down_o[k])
      );
   end

endmodule

// File: tb/tb_s_block.sv
// tb/tb_s_block.sv - scoreboard bench for s_block
module tb_s_block;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        wr_en;
   logic [17:0] bits;
   logic [2:0]  left_i;
   logic [2:0]  up_i;
   logic [2:0]  right_o;
   logic [2:0]  down_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      tag;
      logic [5:0] exp;
   } exp_t;

   exp_t        sb_q[$];
   logic [17:0] m_cfg;

   s_block dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .wr_en   (wr_en),
      .bits    (bits),
      .left_i  (left_i),
      .up_i    (up_i),
      .right_o (right_o),
      .down_o  (down_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got right/down=%b/%b expected %b/%b", tag, got[5:3], got[2:0], exp[5:3], exp[2:0]);
      end
   endtask

   function automatic logic route(input logic [2:0] s, input logic [2:0] l, input logic [2:0] u);
      case (s)
         3'd0: return 1'b0;
         3'd1: return l[0];
         3'd2: return l[1];
         3'd3: return l[2];
         3'd4: return u[0];
         3'd5: return u[1];
         3'd6: return u[2];
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [5:0] model(input logic [17:0] c, input logic [2:0] l, input logic [2:0] u);
      logic [2:0] r, d;
      for (int k = 0; k < 3; k++) begin
         r[k] = route(c[9+3*k +: 3], l, u);
         d[k] = route(c[3*k +: 3], l, u);
      end
      return {r, d};
   endfunction

   task automatic push_exp(input string tag, input logic [5:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      #1;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_empty: got none expected one entry");
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, {right_o, down_o}, e.exp);
      end
   endtask

   // Drive tracks, queue the model's expectation, then compare.
   task automatic drive(input string tag, input logic [2:0] l, input logic [2:0] u);
      left_i = l;
      up_i   = u;
      push_exp(tag, model(m_cfg, l, u));
      check_out();
   endtask

   task automatic write_cfg(input logic [17:0] w);
      @(negedge clk_i);
      bits  = w;
      wr_en = 1'b1;
      push_exp("old_routing_during_write", model(m_cfg, left_i, up_i));
      check_out();
      @(posedge clk_i);
      m_cfg = w;
      #1;
      wr_en = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1;
      wr_en   = 1'b0;
      bits    = '0;
      left_i  = 3'b111;
      up_i    = 3'b111;
      m_cfg   = '0;
      push_exp("reset_state", 6'b000_000);
      check_out();
      repeat (2) @(posedge clk_i);
      #2;
      reset_i = 1'b0;

      write_cfg(18'b111000111111000111);
      left_i = 3'b000; up_i = 3'b000;
      push_exp("const_pattern_0", 6'b101_101);
      check_out();
      left_i = 3'b111; up_i = 3'b111;
      push_exp("const_pattern_1", 6'b101_101);
      check_out();

      write_cfg(18'b011010001110101100);
      left_i = 3'b110; up_i = 3'b011;
      push_exp("straight", 6'b110_011);
      check_out();

      write_cfg(18'b100100100_011011011);
      left_i = 3'b100; up_i = 3'b001;
      push_exp("turn_fanout_1", 6'b111_111);
      check_out();
      left_i = 3'b000; up_i = 3'b000;
      push_exp("turn_fanout_0", 6'b000_000);
      check_out();

      // Write gating: bits wander with wr_en low.
      left_i = 3'b101; up_i = 3'b010;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         bits = 18'($urandom);
         @(posedge clk_i);
         push_exp("gated_hold", model(18'b100100100_011011011, left_i, up_i));
         check_out();
      end
      write_cfg(18'b011010001110101100);
      push_exp("gated_new", 6'b101_010);
      check_out();

      // Asynchronous reset between edges.
      @(negedge clk_i);
      #2;
      reset_i = 1'b1;
      push_exp("async_reset", 6'b000_000);
      check_out();
      @(negedge clk_i);
      wr_en = 1'b1;
      bits  = 18'h3ffff;
      @(posedge clk_i);
      #1;
      wr_en = 1'b0;
      reset_i = 1'b0;
      m_cfg = '0;
      push_exp("reset_beats_wr", 6'b000_000);
      check_out();
      repeat (2) @(posedge clk_i);
      left_i = 3'b111; up_i = 3'b111;
      push_exp("post_reset_hold", 6'b000_000);
      check_out();

      for (int i = 0; i < 12; i++) begin
         write_cfg(18'($urandom));
         for (int j = 0; j < 3; j++)
            drive("random_route", 3'($urandom), 3'($urandom));
      end

      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
